// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
// Imported by the loader top and its instruction RAM.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    DONE,
    ERROR
  } loader_state_e;

  localparam logic [31:0] NopInstr = 32'h0000_0013;
  localparam int          LenBytes = 2;

endpackage

// File: rtl/instr_ram.sv
// Instruction store: one synchronous write port and
// one combinational read port; contents survive reset.
module instr_ram #(
  parameter int RegBits     = 32,
  parameter int MemAddrBits = 8
) (
  input  logic                   clk_i,
  input  logic                   we_i,
  input  logic [MemAddrBits-1:0] waddr_i,
  input  logic [RegBits-1:0]     wdata_i,
  input  logic [MemAddrBits-1:0] raddr_i,
  output logic [RegBits-1:0]     rdata_o
);

  localparam int Depth = 1 << MemAddrBits;

  logic [RegBits-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader feeding the instruction RAM;
// holds the core in reset until a load completes.
module prog_loader
  import loader_pkg::*;
#(
  parameter int RegBits     = 32,
  parameter int MemAddrBits = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_start_i,
  input  logic               byte_valid_i,
  input  logic [7:0]         byte_data_i,
  output logic               byte_ready_o,
  input  logic [RegBits-1:0] pc_i,
  output logic [RegBits-1:0] instr_o,
  output logic               core_rst_no,
  output logic               busy_o,
  output logic               done_o,
  output logic               error_o
);

  localparam int unsigned Depth = 1 << MemAddrBits;

  loader_state_e          state_q;
  logic [15:0]            len_q;
  logic [MemAddrBits:0]   wcnt_q;
  logic [1:0]             bidx_q;
  logic [23:0]            acc_q;

  logic [15:0]            n_full;
  logic                   too_big;
  logic                   last_word;
  logic                   we;
  logic [RegBits-1:0]     wdata;
  logic [RegBits-1:0]     rdata;
  logic                   pc_ok;

  assign n_full    = {byte_data_i, len_q[7:0]};
  assign too_big   = {1'b0, n_full} > 17'(Depth);
  assign last_word = (16'(wcnt_q) + 16'd1) == len_q;

  assign we    = (state_q == DATA) && byte_valid_i
              && (bidx_q == 2'd3);
  assign wdata = {byte_data_i, acc_q};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      len_q   <= '0;
      wcnt_q  <= '0;
      bidx_q  <= '0;
      acc_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE, ERROR: begin
          if (load_start_i) state_q <= LEN_LO;
        end
        LEN_LO: begin
          if (byte_valid_i) begin
            len_q[7:0] <= byte_data_i;
            state_q    <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (byte_valid_i) begin
            len_q[15:8] <= byte_data_i;
            wcnt_q      <= '0;
            bidx_q      <= '0;
            if (n_full == 16'd0)  state_q <= DONE;
            else if (too_big)     state_q <= ERROR;
            else                  state_q <= DATA;
          end
        end
        DATA: begin
          if (byte_valid_i) begin
            // Little-endian: earlier bytes drift toward bit 0.
            acc_q  <= {byte_data_i, acc_q[23:8]};
            bidx_q <= bidx_q + 2'd1;
            if (bidx_q == 2'd3) begin
              wcnt_q <= wcnt_q + 1'b1;
              if (last_word) state_q <= DONE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign byte_ready_o = (state_q == LEN_LO)
                     || (state_q == LEN_HI)
                     || (state_q == DATA);
  assign busy_o       = byte_ready_o;
  assign done_o       = (state_q == DONE);
  assign error_o      = (state_q == ERROR);
  assign core_rst_no  = (state_q == DONE);

  assign pc_ok = (pc_i[1:0] == 2'b00)
              && (pc_i[RegBits-1:MemAddrBits+2] == '0);

  instr_ram #(
    .RegBits     (RegBits),
    .MemAddrBits (MemAddrBits)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (we),
    .waddr_i (wcnt_q[MemAddrBits-1:0]),
    .wdata_i (wdata),
    .raddr_i (pc_i[MemAddrBits+1:2]),
    .rdata_o (rdata)
  );

  assign instr_o = pc_ok ? rdata : NopInstr;

endmodule

// File: doc/prog_loader.md
# prog_loader

Program loader and instruction store upstream of the `riscv` core. Accepts a byte stream carrying a length header and little-endian 32-bit instruction words. Assembles the words and writes them into an internal instruction RAM, holding the core in reset until the load completes. The RAM then serves the core's fetch address combinationally.

## Interface
- `RegBits`, 32: instruction/fetch word width; only 32 is supported.
- `MemAddrBits`, 8: word-address width of the instruction RAM; depth = 2**MemAddrBits words.
- `clk_i` in 1: single clock; all state updates on rising edge.
- `rst_i` in 1: reset, asynchronous, active-low.
- `load_start_i` in 1: single-cycle request to begin a load.
- `byte_valid_i` in 1: stream byte valid.
- `byte_data_i` in 8: stream byte.
- `byte_ready_o` out 1: loader accepts a byte; a transfer occurs when valid and ready are both high at a clock edge.
- `pc_i` in RegBits: core fetch byte address.
- `instr_o` out RegBits: instruction at `pc_i`, combinational.
- `core_rst_no` out 1: active-low reset to the core; high only in DONE.
- `busy_o` out 1: a load is in progress.
- `done_o` out 1: last load completed successfully.
- `error_o` out 1: last load rejected.

## Operation
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, DONE, ERROR. Reset enters IDLE.
- IDLE/DONE/ERROR + `load_start_i` → LEN_LO. In all other states `load_start_i` is ignored.
- LEN_LO: the accepted byte is stored as N[7:0] → LEN_HI.
- LEN_HI: the accepted byte is stored as N[15:8].
  - N == 0 → DONE.
  - N > 2**MemAddrBits → ERROR, with no RAM writes.
  - Otherwise → DATA, with word counter = 0 and byte index = 0.
- DATA: each accepted byte shifts into the assembly register, little-endian: byte index 0 → bits [7:0], …, index 3 → bits [31:24]. Byte index wraps 3→0.
  - On index 3, write RAM[word counter] = {byte, acc[23:0]} at that same edge, then increment the word counter.
  - When the word written is N-1 → DONE.
- `byte_ready_o` = 1 in LEN_LO, LEN_HI and DATA; 0 otherwise. Bytes presented in other states are not consumed.
- `busy_o` = 1 in LEN_LO, LEN_HI and DATA. `done_o` = 1 in DONE. `error_o` = 1 in ERROR. `core_rst_no` = 1 in DONE only.
- Fetch path:
  - `instr_o` = RAM[`pc_i`[MemAddrBits+1:2]] when `pc_i`[1:0] == 0 and `pc_i` < 4·2**MemAddrBits.
  - Otherwise `instr_o` = NOP 32'h0000_0013.
- RAM contents are not cleared by reset or by a new load. Locations at or above N keep their previous values.
- Reset mid-load aborts immediately to IDLE. Words already written remain in the RAM.
- Word counter is MemAddrBits+1 bits wide, so N = 2**MemAddrBits is representable. N is 16 bits.

## Timing
- Reset values: `byte_ready_o` 0, `core_rst_no` 0, `busy_o` 0, `done_o` 0, `error_o` 0, state IDLE, counters 0.
- `load_start_i` at edge k: `busy_o`/`byte_ready_o` are high from k+1, and `core_rst_no` drops at k+1.
- Final data byte accepted at edge k: `done_o` and `core_rst_no` rise at k+1.
- The RAM write at edge k is visible on `instr_o` at k+1. The write happens while the core is in reset, so there is no read/write hazard.
- Throughput: one byte per cycle, with no bubbles required between bytes.
- Load latency is 2 + 4N accepted bytes. There is no fixed timeout; the loader waits indefinitely on `byte_valid_i`.
- All outputs except `instr_o` are registered state decodes, with no combinational path from stream inputs.

## Structure
- Package `loader_pkg`:
  - state enum `loader_state_e`
  - `NopInstr` = 32'h0000_0013
  - `LenBytes` = 2
- Sub-module `instr_ram`:
  - parameters `RegBits`, `MemAddrBits`
  - synchronous write port (we, waddr, wdata)
  - combinational read port (raddr, rdata)
  - no reset on the storage array
- The top level holds the FSM, the length register, the byte/word counters, the assembly register and the fetch-address range/alignment check.

## Test plan
- Load N=2: bytes 02 00 13 05 50 00 93 05 A0 00.
  - → `done_o`=1 one cycle after the last byte.
  - `pc_i`=0 gives 0x0050_0513; `pc_i`=4 gives 0x00A0_0593.
  - `core_rst_no` rises with `done_o`.
- N=0: bytes 00 00 → DONE after the second byte, with no RAM change (previous words still read back).
- N=0x0101 with MemAddrBits=8 → `error_o`=1 and `core_rst_no`=0. Following bytes are not accepted (`byte_ready_o`=0).
- Stalls: deassert `byte_valid_i` for 3 cycles between every byte of an N=1 load → the same word is written. `load_start_i` pulsed mid-load is ignored.
- Fetch bounds: `pc_i`=2 → 0x0000_0013. `pc_i`=0x400 → 0x0000_0013.
- Assert `rst_i`=0 after 5 data bytes of an N=2 load → all outputs return to their reset values and word 0 is retained. A subsequent full reload produces DONE.
